// File: rtl/ppu_frame_sequencer.sv
// PPU raster timing: dot/scanline counters, phase register, vblank flag,
// prerender restart pulse and registered active-low NMI request.
module ppu_frame_sequencer #(
    parameter int unsigned DOTS_PER_LINE   = 341,
    parameter int unsigned LINES_PER_FRAME = 262,
    parameter int unsigned VBLANK_LINE     = 241,
    parameter int unsigned PRERENDER_LINE  = 261
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_ce,
    input  logic       render_en,
    input  logic       nmi_en,
    input  logic       rd_2002,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic       frame_odd,
    output logic [1:0] phase,
    output logic       vblank,
    output logic       ppu_restart,
    output logic       nmi_n,
    output logic       render_active
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] POST_LINE = 9'(VBLANK_LINE - 1);
    localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
    localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

    localparam logic [1:0] PH_RENDER     = 2'd0;
    localparam logic [1:0] PH_POSTRENDER = 2'd1;
    localparam logic [1:0] PH_VBLANK     = 2'd2;
    localparam logic [1:0] PH_PRERENDER  = 2'd3;

    logic [8:0] dot_q, dot_d;
    logic [8:0] scanline_q, scanline_d;
    logic       frame_odd_q, frame_odd_d;
    logic [1:0] phase_q, phase_d;
    logic       vblank_q, vblank_d;
    logic       ppu_restart_q, ppu_restart_d;
    logic       nmi_n_q, nmi_n_d;

    logic skip_dot, line_end, frame_end, set_pending, restart_event;

    function automatic logic [1:0] phase_of(input logic [8:0] line);
        if (line == PRE_LINE)       return PH_PRERENDER;
        else if (line >= VBL_LINE)  return PH_VBLANK;
        else if (line == POST_LINE) return PH_POSTRENDER;
        else                        return PH_RENDER;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        dot_d       = dot_q;
        scanline_d  = scanline_q;
        frame_odd_d = frame_odd_q;
        phase_d     = phase_q;

        // Odd frames with rendering on drop the last dot of the prerender line.
        skip_dot  = frame_odd_q && render_en && (scanline_q == PRE_LINE) && (dot_q == SKIP_DOT);
        line_end  = (dot_q == LAST_DOT) || skip_dot;
        frame_end = skip_dot || ((dot_q == LAST_DOT) && (scanline_q == LAST_LINE));

        if (dot_ce) begin
            if (line_end) begin
                dot_d       = '0;
                scanline_d  = frame_end ? '0 : scanline_q + 9'd1;
                frame_odd_d = frame_odd_q ^ frame_end;
                phase_d     = phase_of(scanline_d);
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end

        // Both events fire on the edge that moves the counters onto dot 1 of their line.
        set_pending   = dot_ce && (scanline_q == VBL_LINE) && (dot_q == 9'd0);
        restart_event = dot_ce && (scanline_q == PRE_LINE) && (dot_q == 9'd0);

        vblank_d = vblank_q;
        if (set_pending && !rd_2002)
            vblank_d = 1'b1;
        if (restart_event || rd_2002)
            vblank_d = 1'b0;

        ppu_restart_d = restart_event;
        nmi_n_d       = ~(vblank_q & nmi_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            dot_q         <= '0;
            scanline_q    <= '0;
            frame_odd_q   <= 1'b0;
            phase_q       <= PH_RENDER;
            vblank_q      <= 1'b0;
            ppu_restart_q <= 1'b0;
            nmi_n_q       <= 1'b1;
        end else begin
            dot_q         <= dot_d;
            scanline_q    <= scanline_d;
            frame_odd_q   <= frame_odd_d;
            phase_q       <= phase_d;
            vblank_q      <= vblank_d;
            ppu_restart_q <= ppu_restart_d;
            nmi_n_q       <= nmi_n_d;
        end
    end

    assign dot           = dot_q;
    assign scanline      = scanline_q;
    assign frame_odd     = frame_odd_q;
    assign phase         = phase_q;
    assign vblank        = vblank_q;
    assign ppu_restart   = ppu_restart_q;
    assign nmi_n         = nmi_n_q;
    assign render_active = render_en && ((phase_q == PH_RENDER) || (phase_q == PH_PRERENDER));

endmodule

// File: tb/tb_ppu_frame_sequencer.sv
// Self-checking bench for ppu_frame_sequencer on a reduced raster (24 dots x 20 lines)
// so whole frames stay short; all expectations scale with the parameters below.
module tb_ppu_frame_sequencer;

    localparam int DPL   = 24;
    localparam int LPF   = 20;
    localparam int VBL   = 14;
    localparam int PRE   = 19;
    localparam int FRAME = DPL * LPF;           // 480 dots
    localparam int SKIP_T = PRE * DPL + DPL - 2; // last dot reached on a shortened frame
    localparam int SET_T  = VBL * DPL + 1;
    localparam int CLR_T  = PRE * DPL + 1;

    logic       clk = 1'b0;
    logic       rst, dot_ce, render_en, nmi_en, rd_2002;
    logic [8:0] dot, scanline;
    logic       frame_odd, vblank, ppu_restart, nmi_n, render_active;
    logic [1:0] phase;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Frame model: linear dot index within the frame plus event flags.
    int m_t     = 0;
    bit m_odd   = 1'b0;
    bit m_vbl   = 1'b0;
    bit m_rst_p = 1'b0;
    bit m_nmi_n = 1'b1;

    ppu_frame_sequencer #(
        .DOTS_PER_LINE  (DPL),
        .LINES_PER_FRAME(LPF),
        .VBLANK_LINE    (VBL),
        .PRERENDER_LINE (PRE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dot_ce       (dot_ce),
        .render_en    (render_en),
        .nmi_en       (nmi_en),
        .rd_2002      (rd_2002),
        .dot          (dot),
        .scanline     (scanline),
        .frame_odd    (frame_odd),
        .phase        (phase),
        .vblank       (vblank),
        .ppu_restart  (ppu_restart),
        .nmi_n        (nmi_n),
        .render_active(render_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_phase(input int line);
        if (line < VBL - 1)       return 0;
        else if (line == VBL - 1) return 1;
        else if (line < PRE)      return 2;
        else                      return 3;
    endfunction

    always @(posedge clk) begin
        int  nt;
        bit  nodd, nv, set_ev, clr_ev;
        if (rst) begin
            m_t     <= 0;
            m_odd   <= 1'b0;
            m_vbl   <= 1'b0;
            m_rst_p <= 1'b0;
            m_nmi_n <= 1'b1;
        end else begin
            nt   = m_t;
            nodd = m_odd;
            if (dot_ce) begin
                if ((m_odd && render_en && m_t == SKIP_T) || (m_t + 1 == FRAME)) begin
                    nt   = 0;
                    nodd = !m_odd;
                end else begin
                    nt = m_t + 1;
                end
            end
            set_ev = dot_ce && (nt == SET_T);
            clr_ev = dot_ce && (nt == CLR_T);
            nv = m_vbl;
            if (set_ev && !rd_2002) nv = 1'b1;
            if (clr_ev || rd_2002)  nv = 1'b0;
            m_nmi_n <= !(m_vbl && nmi_en);
            m_rst_p <= clr_ev;
            m_vbl   <= nv;
            m_t     <= nt;
            m_odd   <= nodd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_dot",       int'(dot),           m_t % DPL);
            check("cmp_scanline",  int'(scanline),      m_t / DPL);
            check("cmp_frame_odd", int'(frame_odd),     int'(m_odd));
            check("cmp_phase",     int'(phase),         exp_phase(m_t / DPL));
            check("cmp_vblank",    int'(vblank),        int'(m_vbl));
            check("cmp_restart",   int'(ppu_restart),   int'(m_rst_p));
            check("cmp_nmi_n",     int'(nmi_n),         int'(m_nmi_n));
            check("cmp_render_active", int'(render_active),
                  int'(render_en && (exp_phase(m_t / DPL) == 0 || exp_phase(m_t / DPL) == 3)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int line, input int dt, input string name);
        int target;
        int n;
        target = line * DPL + dt;
        n = 0;
        while (m_t != target && n < 2 * FRAME) begin
            step();
            n++;
        end
        check(name, m_t, target);
    endtask

    task automatic frame_len(input string name, input int exp);
        logic f;
        int   n;
        f = frame_odd;
        n = 0;
        while (frame_odd == f && n < 2 * FRAME) begin
            step();
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        bit bad;
        rst = 1'b1; dot_ce = 1'b0; render_en = 1'b0; nmi_en = 1'b0; rd_2002 = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("reset_dot",      int'(dot),         0);
        check("reset_scanline", int'(scanline),    0);
        check("reset_vblank",   int'(vblank),      0);
        check("reset_nmi_n",    int'(nmi_n),       1);
        check("reset_phase",    int'(phase),       0);

        // Test 1: count to the vblank set point; POSTRENDER line 13 seen on the way.
        dot_ce = 1'b1; nmi_en = 1'b1;
        repeat (324) step();
        check("t1_post_line",  int'(scanline), 13);
        check("t1_post_dot",   int'(dot),      12);
        check("t1_post_phase", int'(phase),    1);
        repeat (13) step();
        check("t1_set_line",   int'(scanline), 14);
        check("t1_set_dot",    int'(dot),      1);
        check("t1_set_vblank", int'(vblank),   1);
        check("t1_nmi_lag",    int'(nmi_n),    1);
        step();
        check("t1_nmi_low",    int'(nmi_n),    0);

        // Test 2: restart at (19,1) and frame wrap.
        run_to(PRE, 1, "t2_reach_restart");
        check("t2_vblank_clr", int'(vblank),      0);
        check("t2_restart_hi", int'(ppu_restart), 1);
        step();
        check("t2_restart_lo", int'(ppu_restart), 0);
        check("t2_nmi_high",   int'(nmi_n),       1);
        run_to(PRE, DPL - 1, "t2_reach_last");
        check("t2_odd_before", int'(frame_odd), 0);
        step();
        check("t2_wrap_dot",   int'(dot),       0);
        check("t2_wrap_line",  int'(scanline),  0);
        check("t2_odd_after",  int'(frame_odd), 1);

        // Test 3: frame lengths; odd frame with rendering is one dot short (479 vs 480).
        render_en = 1'b1;
        frame_len("t3_odd_render",  479);
        frame_len("t3_even_render", 480);
        render_en = 1'b0;
        frame_len("t3_odd_norender",  480);
        frame_len("t3_even_norender", 480);

        // Test 4: read on the exact set cycle suppresses vblank for the frame.
        run_to(VBL, 0, "t4_reach_set");
        rd_2002 = 1'b1;
        step();
        rd_2002 = 1'b0;
        check("t4_race_vblank", int'(vblank), 0);
        bad = 1'b0;
        while (m_t != PRE * DPL + 2) begin
            step();
            if (vblank || !nmi_n) bad = 1'b1;
        end
        check("t4_race_quiet", int'(bad), 0);
        run_to(VBL + 2, 5, "t4_reach_read");
        check("t4_vblank_set", int'(vblank), 1);
        rd_2002 = 1'b1;
        step();
        rd_2002 = 1'b0;
        check("t4_read_clr",  int'(vblank), 0);
        check("t4_nmi_lag",   int'(nmi_n),  0);
        step();
        check("t4_nmi_high",  int'(nmi_n),  1);

        // Test 5: nmi_en rising while vblank is already high.
        nmi_en = 1'b0;
        run_to(0, 0, "t5_reach_frame");
        run_to(VBL + 4, 0, "t5_reach_enable");
        check("t5_vblank",    int'(vblank), 1);
        check("t5_nmi_quiet", int'(nmi_n),  1);
        nmi_en = 1'b1;
        step();
        check("t5_nmi_low",   int'(nmi_n),  0);

        // Test 6: mid-frame reset overrides dot_ce and rd_2002, then gated counting.
        run_to(0, 0, "t6_reach_frame");
        run_to(5, 10, "t6_reach_reset");
        rst = 1'b1; rd_2002 = 1'b1;
        step();
        rd_2002 = 1'b0;
        check("t6_rst_dot",     int'(dot),         0);
        check("t6_rst_line",    int'(scanline),    0);
        check("t6_rst_odd",     int'(frame_odd),   0);
        check("t6_rst_phase",   int'(phase),       0);
        check("t6_rst_vblank",  int'(vblank),      0);
        check("t6_rst_restart", int'(ppu_restart), 0);
        check("t6_rst_nmi_n",   int'(nmi_n),       1);
        rst = 1'b0; dot_ce = 1'b1;
        step();
        check("t6_ce1_dot", int'(dot), 1);
        dot_ce = 1'b0;
        step();
        check("t6_ce0_dot", int'(dot), 1);
        dot_ce = 1'b1;
        step();
        check("t6_ce1b_dot", int'(dot), 2);

        // Mixed traffic: gapped dot_ce, stray reads and nmi_en toggles against the model.
        render_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            dot_ce  = ($urandom_range(0, 3) != 0);
            rd_2002 = ($urandom_range(0, 40) == 0);
            if (i % 97 == 0) nmi_en = !nmi_en;
            step();
        end
        rd_2002 = 1'b0;
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppu_frame_sequencer.md
# ppu_frame_sequencer

Dot/scanline timing controller for the PPU. Counts the 341×262 NTSC raster and owns the vertical-blank flag, the start-of-frame restart pulse and the CPU NMI request. Sits between the PPU core clock and the status-register logic: status bits 7/6/5 are cleared from its restart pulse, and bit 7 is set and cleared from its vblank state.

## Interface

Parameters:
- DOTS_PER_LINE, 341, dots per scanline (counter wraps at DOTS_PER_LINE-1).
- LINES_PER_FRAME, 262, scanlines per frame.
- VBLANK_LINE, 241, scanline on which vblank is set (dot 1).
- PRERENDER_LINE, 261, scanline on which vblank is cleared and the frame restarts (dot 1).

Ports:
- clk  in  1  PPU clock. One clock domain only.
- rst  in  1  Reset. Synchronous and active-high.
- dot_ce  in  1  Dot enable. Counters and flags advance only when it is 1.
- render_en  in  1  Background or sprite rendering enabled (mask bit 3 | bit 4).
- nmi_en  in  1  Control register bit 7.
- rd_2002  in  1  One-cycle pulse when the CPU reads $2002. Qualified by the bus, not by dot_ce.
- dot  out  9  Current dot, 0..DOTS_PER_LINE-1.
- scanline  out  9  Current scanline, 0..LINES_PER_FRAME-1.
- frame_odd  out  1  Toggles at each frame wrap.
- phase  out  2  0=RENDER, 1=POSTRENDER, 2=VBLANK, 3=PRERENDER.
- vblank  out  1  Status bit 7 source.
- ppu_restart  out  1  One-cycle pulse at PRERENDER_LINE dot 1. Clears sprite-0 hit and overflow.
- nmi_n  out  1  Active-low NMI to the CPU. Value is ~(vblank & nmi_en).
- render_active  out  1  1 when phase is RENDER or PRERENDER and render_en is 1.

## Operation

- Reset values: dot=0, scanline=0, frame_odd=0, phase=RENDER, vblank=0, ppu_restart=0, nmi_n=1. rst overrides every other input, including dot_ce and rd_2002.
- Counting happens on a dot_ce cycle only.
  - dot increments by 1.
  - At DOTS_PER_LINE-1, dot wraps to 0 and scanline increments.
  - At LINES_PER_FRAME-1 with dot wrap, scanline wraps to 0 and frame_odd toggles.
- Odd-frame skip: when frame_odd=1, render_en=1, scanline=PRERENDER_LINE and dot=DOTS_PER_LINE-2, the next dot_ce goes directly to dot 0 of scanline 0. That frame is one dot short.
- Phase register, updated together with the scanline change:
  - RENDER: lines 0..239.
  - POSTRENDER: line 240.
  - VBLANK: VBLANK_LINE..PRERENDER_LINE-1.
  - PRERENDER: PRERENDER_LINE.
  - Phase is a registered state, not decoded combinationally at the outputs.
- vblank set: on the dot_ce cycle that moves the counters to (VBLANK_LINE, 1), vblank becomes 1. The set is recorded in set_pending for that cycle.
- vblank clear:
  - On the dot_ce cycle that moves the counters to (PRERENDER_LINE, 1), vblank becomes 0 and ppu_restart pulses.
  - On a rd_2002 cycle, vblank becomes 0 on the next edge.
- Race rule: if rd_2002 arrives in the same cycle as the set event, the set is suppressed. vblank stays 0 for the whole frame and no NMI is generated. A set event and the restart clear cannot coincide.
- NMI:
  - nmi_n is registered and equals ~(vblank & nmi_en) one cycle later.
  - If nmi_en goes 0→1 while vblank=1, nmi_n asserts again the next cycle.
- ppu_restart is exactly one clk wide, even when dot_ce is held high.

## Timing

- Counter outputs: zero latency relative to the registered state. They change on the edge where dot_ce=1.
- vblank: changes on the same edge as the counter transition into (VBLANK_LINE, 1).
- rd_2002 clear: 1 cycle.
- nmi_n: 1 cycle after vblank or nmi_en changes.
- ppu_restart: high during the cycle after the transition to (PRERENDER_LINE, 1).
- With dot_ce held at 1:
  - Even frame, or rendering disabled: 89342 cycles.
  - Odd frame with rendering enabled: 89341 cycles.
- dot_ce=0 freezes every counter and the set/restart events. rd_2002 and nmi_en are still honoured.
- rst asserted mid-frame: the next edge returns every output to its reset value. Counting resumes from (0, 0) on the first dot_ce after rst is released.

## Test plan

1. Reset, then dot_ce=1 for 241×341+1 cycles. Required: scanline=241, dot=1, vblank=1. One cycle later nmi_n=0 with nmi_en=1. Earlier, phase=1 throughout line 240.
2. Continue to (261, 1). Required: vblank→0, ppu_restart high for exactly 1 cycle, nmi_n→1. Wrap at (261, 340)→(0, 0) with frame_odd=1.
3. render_en=1 over two frames. Required: the even frame is 89342 cycles and the odd frame is 89341 (340 skipped at line 261). Repeat with render_en=0: both frames are 89342.
4. Pulse rd_2002 on the exact set cycle at (241, 1). Required: vblank stays 0 for the frame and nmi_n stays 1. Pulse it at (245, 10) instead: vblank clears the next cycle and nmi_n→1.
5. nmi_en=0 through the vblank set, then nmi_en=1 at (250, 0). Required: nmi_n=0 one cycle later.
6. Assert rst at (120, 200) with dot_ce=1. Required: next cycle all outputs are at reset values. Toggle dot_ce 1-0-1 and check that the counters advance only on the enabled cycles.
